// File: rtl/ex_muldiv_if.sv
// Handshake and operand bundle between the EX-stage pipeline and the iterative
// RV32M multiply/divide unit. The master is the pipeline; the slave is the unit.
interface ex_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start,
        output op,
        output a,
        output b,
        output flush,
        input  busy,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  op,
        input  a,
        input  b,
        input  flush,
        output busy,
        output done,
        output result
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit (radix-2 shift-add multiply, restoring divide).
// Optional macro MULDIV_FAST_MUL_EN: single-cycle combinational multiply, divides stay iterative.
module ex_muldiv #(
    parameter int WIDTH    = 32,
    parameter int CNT_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    ex_muldiv_if.slave  bus
);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state;
    logic [CNT_BITS-1:0] cnt;
    logic [WIDTH-1:0]    result;
    logic [WIDTH-1:0]    hi;
    logic [WIDTH-1:0]    lo;
    logic [WIDTH-1:0]    opb;
    logic [2:0]          op_q;
    logic                neg_q;
    logic                neg_r;

    // Unsigned magnitude; the two's complement of -2^(WIDTH-1) reads back as +2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + ONE_W) : v;
    endfunction

    function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + ONE_W) : v;
    endfunction

    logic             a_signed;
    logic             b_signed;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             b_zero;
    logic             div_ovf;
    logic             short_hit;
    logic [WIDTH-1:0] short_val;

    // Operand decode in IDLE: signedness, magnitudes and divide short-circuit detection.
    always_comb begin
        a_signed  = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                    (bus.op == OP_DIV)  || (bus.op == OP_REM);
        b_signed  = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
        sa        = a_signed & bus.a[WIDTH-1];
        sb        = b_signed & bus.b[WIDTH-1];
        mag_a     = magnitude(bus.a, sa);
        mag_b     = magnitude(bus.b, sb);
        b_zero    = (bus.b == ZERO_W);
        div_ovf   = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                    (bus.a == MIN_NEG) && (bus.b == ONES_W);
        short_hit = bus.op[2] & (b_zero | div_ovf);
        if (b_zero) begin
            short_val = bus.op[1] ? bus.a : ONES_W;
        end else begin
            short_val = bus.op[1] ? ZERO_W : MIN_NEG;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_ext_a;
    logic [2*WIDTH-1:0] fast_ext_b;
    logic [2*WIDTH-1:0] fast_prod;

    // Low 2*WIDTH bits of the sign/zero-extended product are exact for every signedness mix.
    always_comb begin
        fast_ext_a = {{WIDTH{sa}}, bus.a};
        fast_ext_b = {{WIDTH{sb}}, bus.b};
        fast_prod  = fast_ext_a * fast_ext_b;
    end
`endif

    logic [WIDTH:0]   shifted;
    logic             take;
    logic [WIDTH-1:0] sub;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] next_hi;
    logic [WIDTH-1:0] next_lo;

    // One CALC iteration: restoring divide step or shift-add multiply step sharing hi/lo.
    always_comb begin
        shifted = {hi, lo[WIDTH-1]};
        take    = (shifted >= {1'b0, opb});
        sub     = shifted[WIDTH-1:0] - opb;
        sum     = {1'b0, hi} + {1'b0, (lo[0] ? opb : ZERO_W)};
        if (op_q[2]) begin
            next_hi = take ? sub : shifted[WIDTH-1:0];
            next_lo = {lo[WIDTH-2:0], take};
        end else begin
            next_hi = sum[WIDTH:1];
            next_lo = {sum[0], lo[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod_adj;
    logic [WIDTH-1:0]   fix_val;

    // Sign correction applied in FIX; hi holds the remainder, lo the quotient after a divide.
    always_comb begin
        prod_adj = neg_q ? (~{hi, lo} + ONE_2W) : {hi, lo};
        case (op_q)
            OP_MUL:    fix_val = prod_adj[WIDTH-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  fix_val = prod_adj[2*WIDTH-1:WIDTH];
            OP_DIV,
            OP_DIVU:   fix_val = negate_if(lo, neg_q);
            OP_REM,
            OP_REMU:   fix_val = negate_if(hi, neg_r);
            default:   fix_val = ZERO_W;
        endcase
    end

    // Control FSM with datapath registers; flush outranks everything except reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= CNT_ZERO;
            result <= ZERO_W;
            hi     <= ZERO_W;
            lo     <= ZERO_W;
            opb    <= ZERO_W;
            op_q   <= 3'd0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (bus.flush) begin
            state <= IDLE;
            cnt   <= CNT_ZERO;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= CNT_ZERO;
                    if (bus.start) begin
                        if (short_hit) begin
                            result <= short_val;
                            state  <= DONE;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!bus.op[2]) begin
                            result <= (bus.op == OP_MUL) ? fast_prod[WIDTH-1:0]
                                                         : fast_prod[2*WIDTH-1:WIDTH];
                            state  <= DONE;
`endif
                        end else begin
                            hi    <= ZERO_W;
                            lo    <= mag_a;
                            opb   <= mag_b;
                            op_q  <= bus.op;
                            neg_q <= sa ^ sb;
                            neg_r <= sa;
                            state <= CALC;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    hi <= next_hi;
                    lo <= next_lo;
                    if (cnt == CNT_LAST) begin
                        cnt   <= CNT_ZERO;
                        state <= FIX;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                FIX: begin
                    result <= fix_val;
                    state  <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign bus.busy   = ((state == IDLE) & bus.start & ~bus.flush) |
                        (state == CALC) | (state == FIX);
    assign bus.done   = (state == DONE);
    assign bus.result = result;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv: reset, multiplies, divides,
// short-circuit corners, flush abort and back-to-back issue.
module tb_ex_muldiv;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_BUSY = 1;
`else
    localparam int MUL_BUSY = 34;
`endif
    localparam int DIV_BUSY = 34;

    logic clk;
    logic rst;
    int   checks;
    int   passed;
    int   fails;

    ex_muldiv_if #(.WIDTH(32)) bus ();

    ex_muldiv #(.WIDTH(32), .CNT_BITS(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp, input int exp_busy, input string tag);
        int busy_cnt;
        busy_cnt = 0;
        @(negedge clk);
        bus.op    = o;
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (bus.done) break;
            if (bus.busy) busy_cnt++;
            @(negedge clk);
        end
        check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
        bus.start = 1'b0;
        check({tag, "_result"}, bus.result, exp);
        check({tag, "_busy"}, busy_cnt, exp_busy);
        @(negedge clk);
        #1;
        check({tag, "_pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
    endtask

    initial begin
        int pulses;
        logic [31:0] res0;
        logic [31:0] res1;
        checks    = 0;
        passed    = 0;
        fails     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 3'd0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_result", bus.result, 32'd0);
        rst = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_BUSY, "mul_7_m3");
        run_op(3'd1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, MUL_BUSY, "mulh");
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, MUL_BUSY, "mulhu");
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, MUL_BUSY, "mulhsu");
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, DIV_BUSY, "div_m7_2");
        run_op(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, DIV_BUSY, "rem_m7_2");
        run_op(3'd5, 32'd100, 32'd7, 32'd14, DIV_BUSY, "divu_100_7");
        run_op(3'd7, 32'd100, 32'd7, 32'd2, DIV_BUSY, "remu_100_7");

        // Flush at CALC iteration 10 with start still high.
        @(negedge clk);
        bus.op    = 3'd5;
        bus.a     = 32'd1000;
        bus.b     = 32'd3;
        bus.start = 1'b1;
        repeat (11) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        #1;
        check("flush_busy", {31'd0, bus.busy}, 32'd0);
        check("flush_done", {31'd0, bus.done}, 32'd0);
        bus.flush = 1'b0;
        bus.start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("flush_no_done", pulses, 32'd0);
        check("flush_result_kept", bus.result, 32'd2);

        // Back-to-back DIVU with start held high.
        @(negedge clk);
        bus.op    = 3'd5;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        bus.start = 1'b1;
        pulses    = 0;
        res0      = 32'd0;
        res1      = 32'd0;
        for (int i = 0; i < 120; i++) begin
            #1;
            if (bus.done) begin
                pulses++;
                if (pulses == 1) begin
                    res0  = bus.result;
                    bus.a = 32'd45;
                    bus.b = 32'd6;
                end else begin
                    res1      = bus.result;
                    bus.start = 1'b0;
                end
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("b2b_pulses", pulses, 32'd2);
        check("b2b_first", res0, 32'd14);
        check("b2b_second", res1, 32'd7);

        run_op(3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "div_by_zero");
        run_op(3'd7, 32'd5, 32'd0, 32'd5, 1, "remu_by_zero");
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, "rem_ovf");
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        bus.op    = 3'd5;
        bus.a     = 32'd77;
        bus.b     = 32'd5;
        bus.start = 1'b1;
        repeat (10) @(negedge clk);
        bus.start = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_done", {31'd0, bus.done}, 32'd0);
        check("arst_result", bus.result, 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.busy || bus.done) pulses++;
        end
        check("arst_stays_idle", pulses, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
